// File: rtl/bsg_wormhole_traffic_endpoint.sv
// Wormhole traffic endpoint: sends numbered header+body packets and checks incoming ones.
// Link bundle packing is {v, data, ready_and_rev} from MSB to LSB.
module bsg_wormhole_traffic_endpoint #(
    parameter int flit_width_p = 32,
    parameter int cord_width_p = 8,
    parameter int len_width_p  = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [cord_width_p-1:0]   my_cord_i,
    input  logic [cord_width_p-1:0]   dest_cord_i,
    input  logic                      start_i,
    input  logic [15:0]               num_packets_i,
    input  logic [len_width_p-1:0]    packet_len_i,
    input  logic [flit_width_p+1:0]   link_i,
    output logic [flit_width_p+1:0]   link_o,
    output logic                      tx_done_o,
    output logic [15:0]               tx_count_o,
    output logic [15:0]               rx_count_o,
    output logic                      error_o
);

    typedef logic [flit_width_p-1:0] flit_t;
    typedef logic [len_width_p-1:0]  len_t;
    typedef logic [cord_width_p-1:0] cord_t;

    typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_BODY, TX_DONE} tx_state_e;
    typedef enum logic       {RX_HDR, RX_BODY} rx_state_e;

    tx_state_e tx_state_q, tx_state_d;
    cord_t     dest_q, dest_d, my_q, my_d;
    logic [15:0] num_q, num_d, tx_count_q, tx_count_d;
    len_t      len_q, len_d, tx_cnt_q, tx_cnt_d;
    flit_t     tx_seq_q, tx_seq_d;

    rx_state_e rx_state_q, rx_state_d;
    len_t      rx_len_q, rx_len_d, rx_cnt_q, rx_cnt_d;
    flit_t     rx_seq_q, rx_seq_d;
    logic [15:0] rx_count_q, rx_count_d;
    logic      error_q, error_d;

    logic  tx_vld, tx_fire, rx_rdy, rx_vld, rx_fire;
    flit_t tx_dat, hdr_dat, rx_dat;

    // Valid comes only from registered state; reset masks it in the reset cycle itself.
    assign tx_vld  = ((tx_state_q == TX_HDR) || (tx_state_q == TX_BODY)) && !reset_i;
    assign tx_fire = tx_vld && link_i[0];
    assign hdr_dat = (flit_t'(my_q) << (cord_width_p + len_width_p))
                   | (flit_t'(len_q) << cord_width_p)
                   | flit_t'(dest_q);
    assign tx_dat  = (tx_state_q == TX_HDR) ? hdr_dat
                   : (tx_state_q == TX_BODY) ? tx_seq_q : '0;

    assign rx_rdy  = !reset_i;
    assign rx_vld  = link_i[flit_width_p+1];
    assign rx_dat  = link_i[flit_width_p:1];
    assign rx_fire = rx_vld && rx_rdy;

    assign link_o     = {tx_vld, tx_dat, rx_rdy};
    assign tx_done_o  = (tx_state_q == TX_DONE) && !reset_i;
    assign tx_count_o = tx_count_q;
    assign rx_count_o = rx_count_q;
    assign error_o    = error_q;

    always_comb begin
        logic finish;
        finish     = 1'b0;
        tx_state_d = tx_state_q;
        dest_d     = dest_q;
        my_d       = my_q;
        num_d      = num_q;
        len_d      = len_q;
        tx_cnt_d   = tx_cnt_q;
        tx_seq_d   = tx_seq_q;
        tx_count_d = tx_count_q;
        case (tx_state_q)
            TX_IDLE, TX_DONE: begin
                if (start_i) begin
                    dest_d     = dest_cord_i;
                    my_d       = my_cord_i;
                    num_d      = num_packets_i;
                    len_d      = packet_len_i;
                    tx_count_d = '0;
                    tx_state_d = (num_packets_i != 16'd0) ? TX_HDR : TX_DONE;
                end
            end
            TX_HDR: begin
                if (tx_fire) begin
                    if (len_q != '0) begin
                        tx_cnt_d   = '0;
                        tx_state_d = TX_BODY;
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            TX_BODY: begin
                if (tx_fire) begin
                    tx_seq_d = tx_seq_q + flit_t'(1);
                    if (tx_cnt_q == len_q - len_t'(1)) finish = 1'b1;
                    else tx_cnt_d = tx_cnt_q + len_t'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        // tx_count_q < num_q always holds here, so the +1 cannot overflow the compare.
        if (finish) begin
            tx_count_d = tx_count_q + 16'd1;
            tx_state_d = (tx_count_q + 16'd1 < num_q) ? TX_HDR : TX_DONE;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_len_d   = rx_len_q;
        rx_cnt_d   = rx_cnt_q;
        rx_seq_d   = rx_seq_q;
        rx_count_d = rx_count_q;
        error_d    = error_q;
        case (rx_state_q)
            RX_HDR: begin
                if (rx_fire) begin
                    rx_len_d = rx_dat[cord_width_p +: len_width_p];
                    if (rx_dat[cord_width_p-1:0] != my_cord_i) error_d = 1'b1;
                    if (rx_dat[cord_width_p +: len_width_p] != '0) begin
                        rx_cnt_d   = '0;
                        rx_state_d = RX_BODY;
                    end else begin
                        rx_count_d = rx_count_q + 16'd1;
                    end
                end
            end
            RX_BODY: begin
                if (rx_fire) begin
                    if (rx_dat != rx_seq_q) error_d = 1'b1;
                    rx_seq_d = rx_seq_q + flit_t'(1);
                    if (rx_cnt_q == rx_len_q - len_t'(1)) begin
                        rx_count_d = rx_count_q + 16'd1;
                        rx_state_d = RX_HDR;
                    end else begin
                        rx_cnt_d = rx_cnt_q + len_t'(1);
                    end
                end
            end
            default: rx_state_d = RX_HDR;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tx_state_q <= TX_IDLE;
            dest_q     <= '0;
            my_q       <= '0;
            num_q      <= '0;
            len_q      <= '0;
            tx_cnt_q   <= '0;
            tx_seq_q   <= '0;
            tx_count_q <= '0;
            rx_state_q <= RX_HDR;
            rx_len_q   <= '0;
            rx_cnt_q   <= '0;
            rx_seq_q   <= '0;
            rx_count_q <= '0;
            error_q    <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            dest_q     <= dest_d;
            my_q       <= my_d;
            num_q      <= num_d;
            len_q      <= len_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_seq_q   <= tx_seq_d;
            tx_count_q <= tx_count_d;
            rx_state_q <= rx_state_d;
            rx_len_q   <= rx_len_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_seq_q   <= rx_seq_d;
            rx_count_q <= rx_count_d;
            error_q    <= error_d;
        end
    end

endmodule

// File: tb/tb_bsg_wormhole_traffic_endpoint.sv
// Bench for bsg_wormhole_traffic_endpoint: loopback and injected traffic against a flit-list model.
module tb_bsg_wormhole_traffic_endpoint;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [7:0]  my_cord_i, dest_cord_i;
    logic        start_i;
    logic [15:0] num_packets_i;
    logic [3:0]  packet_len_i;
    logic [33:0] link_i, link_o;
    logic        tx_done_o, error_o;
    logic [15:0] tx_count_o, rx_count_o;

    logic        loop, force_stall, rand_stall, rnd_bit, tb_rdy;
    logic        inj_v;
    logic [31:0] inj_dat;

    int checks = 0;
    int failures = 0;
    int v_cycles = 0;
    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_seq;
    int          exp_rx;

    always #5 clk = ~clk;

    bsg_wormhole_traffic_endpoint dut (
        .clk_i(clk), .reset_i(reset_i), .my_cord_i(my_cord_i), .dest_cord_i(dest_cord_i),
        .start_i(start_i), .num_packets_i(num_packets_i), .packet_len_i(packet_len_i),
        .link_i(link_i), .link_o(link_o), .tx_done_o(tx_done_o),
        .tx_count_o(tx_count_o), .rx_count_o(rx_count_o), .error_o(error_o)
    );

    always @(posedge clk) rnd_bit <= ($urandom_range(0, 3) != 0);

    always_comb begin
        tb_rdy = force_stall ? 1'b0 : (rand_stall ? rnd_bit : 1'b1);
        if (loop) link_i = {link_o[33] & tb_rdy, link_o[32:1], link_o[0] & tb_rdy};
        else      link_i = {inj_v, inj_dat, 1'b1};
    end

    always @(negedge clk) begin
        if (!reset_i && link_o[33] && link_i[0]) obs_q.push_back(link_o[32:1]);
        if (link_o[33]) v_cycles++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hdr_of(input logic [7:0] my, input logic [3:0] len, input logic [7:0] dest);
        return (32'(my) << 12) | (32'(len) << 8) | 32'(dest);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        exp_seq = 0;
        exp_rx  = 0;
    endtask

    task automatic launch(input int num, input int len, input logic [7:0] cord);
        obs_q.delete();
        exp_q.delete();
        for (int p = 0; p < num; p++) begin
            exp_q.push_back(hdr_of(cord, 4'(len), cord));
            for (int k = 0; k < len; k++) begin
                exp_q.push_back(exp_seq);
                exp_seq = exp_seq + 1;
            end
        end
        exp_rx += num;
        my_cord_i     = cord;
        dest_cord_i   = cord;
        num_packets_i = 16'(num);
        packet_len_i  = 4'(len);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic finish_check(input string tag, input int num);
        for (int i = 0; i < 2000 && !tx_done_o; i++) tick();
        chk({tag, "_done"}, tx_done_o, 1);
        chk({tag, "_nflits"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk({tag, "_flit"}, obs_q[i], exp_q[i]);
        chk({tag, "_txcnt"}, tx_count_o, num);
        chk({tag, "_rxcnt"}, rx_count_o, 16'(exp_rx));
        chk({tag, "_err"}, error_o, 0);
    endtask

    task automatic inject(input logic [31:0] d);
        inj_v   = 1'b1;
        inj_dat = d;
        tick();
        inj_v = 1'b0;
    endtask

    initial begin
        int vc;
        reset_i = 1'b1; loop = 1'b1; force_stall = 1'b0; rand_stall = 1'b0;
        inj_v = 1'b0; inj_dat = '0; start_i = 1'b0;
        my_cord_i = 8'd3; dest_cord_i = 8'd3; num_packets_i = '0; packet_len_i = '0;
        exp_seq = 0; exp_rx = 0;
        tick(); tick();
        chk("rst_v", link_o[33], 0);
        chk("rst_rdy", link_o[0], 0);
        chk("rst_done", tx_done_o, 0);
        reset_i = 1'b0;
        tick();
        chk("post_rst_rdy", link_o[0], 1);
        chk("post_rst_counts", {tx_count_o, rx_count_o}, 0);
        chk("post_rst_err", error_o, 0);
        chk("post_rst_done", tx_done_o, 0);

        launch(2, 2, 8'd3);
        finish_check("basic", 2);
        launch(3, 0, 8'd3);
        finish_check("hdr_only", 3);

        vc = v_cycles;
        launch(0, 2, 8'd3);
        chk("num0_done", tx_done_o, 1);
        tick(); tick();
        chk("num0_nov", v_cycles, vc);
        chk("num0_txcnt", tx_count_o, 0);

        force_stall = 1'b1;
        launch(1, 1, 8'd3);
        for (int i = 0; i < 5; i++) begin
            chk("stall_v", link_o[33], 1);
            chk("stall_dat", link_o[32:1], hdr_of(8'd3, 4'd1, 8'd3));
            chk("stall_cnt", {tx_count_o, rx_count_o}, {16'd0, 16'(exp_rx - 1)});
            tick();
        end
        force_stall = 1'b0;
        finish_check("stall", 1);

        rand_stall = 1'b1;
        for (int it = 0; it < 6; it++) begin
            int n, l;
            n = $urandom_range(1, 3);
            l = $urandom_range(0, 4);
            launch(n, l, 8'($urandom_range(0, 255)));
            finish_check("rand", n);
        end
        rand_stall = 1'b0;

        loop = 1'b0;
        my_cord_i = 8'd3;
        inject(hdr_of(8'd9, 4'd0, 8'd5));
        chk("bad_dest_err", error_o, 1);
        tick(); tick(); tick();
        chk("err_sticky", error_o, 1);
        do_reset();
        chk("err_cleared", error_o, 0);
        inject(hdr_of(8'd9, 4'd1, 8'd3));
        chk("good_hdr_err", error_o, 0);
        inject(32'd7);
        chk("bad_body_err", error_o, 1);
        chk("inj_rxcnt", rx_count_o, 1);
        do_reset();
        loop = 1'b1;

        launch(1, 5, 8'd3);
        for (int i = 0; i < 100 && obs_q.size() < 3; i++) tick();
        chk("mid_reach", obs_q.size() >= 3, 1);
        reset_i = 1'b1;
        #1;
        chk("mid_rst_v_now", link_o[33], 0);
        tick();
        chk("mid_rst_v", link_o[33], 0);
        chk("mid_rst_counts", {tx_count_o, rx_count_o}, 0);
        reset_i = 1'b0;
        exp_seq = 0;
        exp_rx  = 0;
        tick();
        chk("mid_after_v", link_o[33], 0);
        launch(1, 2, 8'd3);
        finish_check("after_rst", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
